btc_header_feeder: RTL and testbench

Upstream message source for `sha256_stream` in the Bitcoin double-SHA-256 datapath. Holds the 80-byte block header and, per nonce, sequences the compressions: midstate (once per run), header tail plus nonce, then digest rehash. It serves message words over the hasher's addr/rq/rdy bus and emits one final 256-bit hash per nonce for the downstream target comparator.

---
 rtl/btc_pkg.sv | 32 +++
 rtl/btc_word_mux.sv | 37 +++
 rtl/btc_header_feeder.sv | 198 +++++++++++++++++++
 tb/tb_btc_header_feeder.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btc_pkg.sv
// Shared constants and types for the Bitcoin header feeder.
// SHA-256 IV, padding words, FSM state and pass encodings.
package btc_pkg;

  localparam int HDR_WORDS = 19;

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] PAD_BIT = 32'h8000_0000;
  localparam logic [31:0] LEN_80B = 32'h0000_0280;
  localparam logic [31:0] LEN_32B = 32'h0000_0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_EMIT
  } state_t;

  typedef enum logic [1:0] {
    P_MID  = 2'd0,
    P_TAIL = 2'd1,
    P_DIG  = 2'd2
  } pass_t;

  typedef logic [HDR_WORDS-1:0][31:0] hdr_t;

endpackage

// File: rtl/btc_word_mux.sv
// Message word selection for the three compression passes.
// Pure combinational: (pass, addr, header, nonce, first digest) -> word.
module btc_word_mux
  import btc_pkg::*;
(
  input  pass_t         pass,
  input  logic [3:0]    addr,
  input  hdr_t          hdr,
  input  logic [31:0]   nonce,
  input  logic [255:0]  d1,
  output logic [31:0]   word
);

  logic [2:0] di;

  always_comb begin
    word = '0;
    di   = 3'd7 - addr[2:0];
    case (pass)
      P_MID: word = hdr[{1'b0, addr}];
      P_TAIL: begin
        if (addr < 4'd3)       word = hdr[5'd16 + {3'b0, addr[1:0]}];
        else if (addr == 4'd3) word = nonce;
        else if (addr == 4'd4) word = PAD_BIT;
        else if (addr == 4'd15) word = LEN_80B;
      end
      P_DIG: begin
        // H0 sits in the top word of the digest
        if (addr < 4'd8)       word = d1[{di, 5'd0} +: 32];
        else if (addr == 4'd8) word = PAD_BIT;
        else if (addr == 4'd15) word = LEN_32B;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/btc_header_feeder.sv
// Sequences midstate, header-tail and rehash compressions per nonce
// and serves message words to the SHA-256 stream hasher.
module btc_header_feeder
  import btc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_we,
  input  logic [4:0]   ld_addr,
  input  logic [31:0]  ld_data,
  input  logic         go,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_count,
  input  logic         stop,
  output logic         hs_start,
  output logic [255:0] hs_state_in,
  input  logic [3:0]   hs_addr,
  input  logic         hs_rq,
  output logic         hs_rdy,
  output logic [31:0]  hs_data,
  input  logic [255:0] hs_state_out,
  input  logic         hs_done,
  output logic         busy,
  output logic         hash_valid,
  output logic [255:0] hash_out,
  output logic [31:0]  nonce_out
);

  state_t state_q, state_d;
  pass_t pass_q, pass_d;
  hdr_t hdr_q, hdr_d;
  logic [255:0] mid_q, mid_d, d1_q, d1_d;
  logic [255:0] sin_q, sin_d, hout_q, hout_d;
  logic [31:0] nonce_q, nonce_d, rem_q, rem_d;
  logic [31:0] data_q, data_d, nout_q, nout_d;
  logic [3:0] cnt_q, cnt_d;
  logic stop_q, stop_d, busy_q, busy_d;
  logic start_q, start_d, rdy_q, rdy_d;
  logic hv_q, hv_d;
  logic [31:0] word;
  logic stop_pend;

  btc_word_mux u_mux (
    .pass  (pass_q),
    .addr  (hs_addr),
    .hdr   (hdr_q),
    .nonce (nonce_q),
    .d1    (d1_q),
    .word  (word)
  );

  assign stop_pend = stop_q | stop;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    hdr_d   = hdr_q;
    mid_d   = mid_q;
    d1_d    = d1_q;
    sin_d   = sin_q;
    hout_d  = hout_q;
    nonce_d = nonce_q;
    rem_d   = rem_q;
    data_d  = data_q;
    nout_d  = nout_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    stop_d  = stop_q | stop;
    start_d = 1'b0;
    rdy_d   = 1'b0;
    hv_d    = 1'b0;
    if (ld_we && !busy_q && ld_addr < 5'(HDR_WORDS))
      hdr_d[ld_addr] = ld_data;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (go && nonce_count != '0) begin
          nonce_d = nonce_start;
          // stop arriving with go still lets the first nonce finish
          rem_d   = stop ? 32'd1 : nonce_count;
          pass_d  = P_MID;
          sin_d   = SHA_IV;
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (hs_rq && !rdy_q) begin
          rdy_d  = 1'b1;
          data_d = word;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hs_done) begin
          case (pass_q)
            P_MID: begin
              mid_d   = hs_state_out;
              pass_d  = P_TAIL;
              sin_d   = hs_state_out;
            end
            P_TAIL: begin
              d1_d    = hs_state_out;
              pass_d  = P_DIG;
              sin_d   = SHA_IV;
            end
            default: begin
              hv_d    = 1'b1;
              hout_d  = hs_state_out;
              nout_d  = nonce_q;
            end
          endcase
          if (pass_q == P_DIG) begin
            state_d = S_EMIT;
          end else if (stop_pend) begin
            busy_d  = 1'b0;
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            start_d = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_EMIT: begin
        if (rem_q == 32'd1 || stop_pend) begin
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d   = rem_q - 32'd1;
          nonce_d = nonce_q + 32'd1;
          pass_d  = P_TAIL;
          sin_d   = mid_q;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pass_q  <= P_MID;
      hdr_q   <= '0;
      mid_q   <= '0;
      d1_q    <= '0;
      sin_q   <= SHA_IV;
      hout_q  <= '0;
      nonce_q <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      nout_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      start_q <= 1'b0;
      rdy_q   <= 1'b0;
      hv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      hdr_q   <= hdr_d;
      mid_q   <= mid_d;
      d1_q    <= d1_d;
      sin_q   <= sin_d;
      hout_q  <= hout_d;
      nonce_q <= nonce_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      nout_q  <= nout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      start_q <= start_d;
      rdy_q   <= rdy_d;
      hv_q    <= hv_d;
    end
  end

  assign hs_start    = start_q;
  assign hs_state_in = sin_q;
  assign hs_rdy      = rdy_q;
  assign hs_data     = data_q;
  assign busy        = busy_q;
  assign hash_valid  = hv_q;
  assign hash_out    = hout_q;
  assign nonce_out   = nout_q;

endmodule

// File: tb/tb_btc_header_feeder.sv
// Bench for btc_header_feeder: behavioural SHA-256 hasher neighbour
// plus a byte-level double-SHA-256 reference for every nonce.
module tb_btc_header_feeder;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] GEN_HDR [19] = '{
    32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
    32'h29ab5f49, 32'hffff001d
  };

  localparam logic [255:0] GEN_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [31:0] GEN_NONCE = 32'h1DAC2B7C;

  typedef struct packed {
    logic [31:0]  n;
    logic [255:0] h;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_we = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic go = 1'b0;
  logic [31:0] nonce_start = '0;
  logic [31:0] nonce_count = '0;
  logic stop = 1'b0;
  logic hs_start;
  logic [255:0] hs_state_in;
  logic [3:0] hs_addr = '0;
  logic hs_rq = 1'b0;
  logic hs_rdy;
  logic [31:0] hs_data;
  logic [255:0] hs_state_out = '0;
  logic hs_done = 1'b0;
  logic busy;
  logic hash_valid;
  logic [255:0] hash_out;
  logic [31:0] nonce_out;

  int n_cmp = 0;
  int n_err = 0;
  int starts = 0;
  int pass0_starts = 0;
  res_t resq[$];
  logic [31:0] ref_hdr [19];

  bit hm_busy = 1'b0;
  int hm_i = 0;
  int hm_wait = 0;
  logic [255:0] hm_st = '0;
  logic [15:0][31:0] hm_w = '0;

  btc_header_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .go           (go),
    .nonce_start  (nonce_start),
    .nonce_count  (nonce_count),
    .stop         (stop),
    .hs_start     (hs_start),
    .hs_state_in  (hs_state_in),
    .hs_addr      (hs_addr),
    .hs_rq        (hs_rq),
    .hs_rdy       (hs_rdy),
    .hs_data      (hs_data),
    .hs_state_out (hs_state_out),
    .hs_done      (hs_done),
    .busy         (busy),
    .hash_valid   (hash_valid),
    .hash_out     (hash_out),
    .nonce_out    (nonce_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(
    input logic [255:0] st, input logic [15:0][31:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c,
            st[159:128] + d, st[127:96] + e, st[95:64] + f,
            st[63:32] + g, st[31:0] + h};
  endfunction

  function automatic logic [255:0] sha256_bytes(input logic [7:0] m[$]);
    logic [7:0] p[$];
    logic [255:0] st;
    logic [15:0][31:0] blk;
    longint unsigned bits;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    st = IV;
    for (int o = 0; o < p.size(); o += 64) begin
      for (int t = 0; t < 16; t++)
        blk[t] = {p[o+4*t], p[o+4*t+1], p[o+4*t+2], p[o+4*t+3]};
      st = sha_compress(st, blk);
    end
    return st;
  endfunction

  function automatic logic [255:0] ref_hash(input logic [31:0] nonce);
    logic [7:0] m[$];
    logic [255:0] d;
    for (int i = 0; i < 19; i++)
      for (int b = 3; b >= 0; b--) m.push_back(ref_hdr[i][8*b +: 8]);
    for (int b = 3; b >= 0; b--) m.push_back(nonce[8*b +: 8]);
    d = sha256_bytes(m);
    m.delete();
    for (int b = 31; b >= 0; b--) m.push_back(d[8*b +: 8]);
    return sha256_bytes(m);
  endfunction

  // hasher neighbour: fetch 16 words in order, compress, pulse done
  always @(negedge clk) begin
    if (rst) begin
      hm_busy = 1'b0;
      hs_rq = 1'b0;
      hs_done = 1'b0;
      hs_addr = '0;
    end else begin
      hs_done = 1'b0;
      if (!hm_busy) begin
        if (hs_start) begin
          hm_busy = 1'b1;
          hm_st = hs_state_in;
          hm_i = 0;
          hs_addr = '0;
          hs_rq = 1'b1;
        end
      end else if (hs_rq) begin
        if (hs_rdy) begin
          hm_w[hm_i] = hs_data;
          if (hm_i == 15) begin
            hs_rq = 1'b0;
            hm_wait = $urandom_range(1, 4);
          end else begin
            hm_i++;
            hs_addr = 4'(hm_i);
          end
        end
      end else if (hm_wait > 1) begin
        hm_wait--;
      end else begin
        if (hm_st == IV && hm_w[15] != 32'h100) pass0_starts++;
        hs_state_out = sha_compress(hm_st, hm_w);
        hs_done = 1'b1;
        hm_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hs_start) starts++;
      if (hash_valid) resq.push_back({nonce_out, hash_out});
    end
  end

  task automatic clear_log();
    resq.delete();
    starts = 0;
    pass0_starts = 0;
  endtask

  task automatic write_hdr();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ld_we = 1'b1;
      ld_addr = 5'(i);
      ld_data = ref_hdr[i];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic set_genesis();
    for (int i = 0; i < 19; i++) ref_hdr[i] = GEN_HDR[i];
    write_hdr();
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s timeout: busy=%0b required 0", tag, busy);
    end
  endtask

  task automatic run(input logic [31:0] st, input logic [31:0] cnt,
                     input bit with_stop, input string tag);
    clear_log();
    @(negedge clk);
    go = 1'b1;
    nonce_start = st;
    nonce_count = cnt;
    stop = with_stop;
    @(negedge clk);
    go = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    wait_idle(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp += 8;
    if (hs_start !== 1'b0) begin n_err++; $display("FAIL rst_start got %0b req 0", hs_start); end
    if (hs_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy got %0b req 0", hs_rdy); end
    if (hs_data !== '0) begin n_err++; $display("FAIL rst_data got %h req 0", hs_data); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b req 0", busy); end
    if (hash_valid !== 1'b0) begin n_err++; $display("FAIL rst_hv got %0b req 0", hash_valid); end
    if (hash_out !== '0) begin n_err++; $display("FAIL rst_hash got %h req 0", hash_out); end
    if (nonce_out !== '0) begin n_err++; $display("FAIL rst_nonce got %h req 0", nonce_out); end
    if (hs_state_in !== IV) begin n_err++; $display("FAIL rst_sin got %h req %h", hs_state_in, IV); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_genesis();
    res_t r;
    set_genesis();
    run(GEN_NONCE, 32'd1, 1'b0, "genesis");
    r = (resq.size() > 0) ? resq[0] : '0;
    n_cmp += 4;
    if (resq.size() !== 1) begin n_err++; $display("FAIL gen_count got %0d req 1", resq.size()); end
    if (r.h !== GEN_HASH) begin n_err++; $display("FAIL gen_hash got %h req %h", r.h, GEN_HASH); end
    if (r.n !== GEN_NONCE) begin n_err++; $display("FAIL gen_nonce got %h req %h", r.n, GEN_NONCE); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL gen_busy got %0b req 0", busy); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    logic [31:0] n;
    run(32'h1DAC2B7A, 32'd3, 1'b0, "b2b");
    n_cmp += 4;
    if (resq.size() !== 3) begin n_err++; $display("FAIL b2b_count got %0d req 3", resq.size()); end
    if (starts !== 7) begin n_err++; $display("FAIL b2b_starts got %0d req 7", starts); end
    if (pass0_starts !== 1) begin n_err++; $display("FAIL b2b_pass0 got %0d req 1", pass0_starts); end
    r = (resq.size() > 2) ? resq[2] : '0;
    if (r.h !== GEN_HASH) begin n_err++; $display("FAIL b2b_third got %h req %h", r.h, GEN_HASH); end
    for (int i = 0; i < 3; i++) begin
      n = 32'h1DAC2B7A + 32'(i);
      r = (resq.size() > i) ? resq[i] : '0;
      n_cmp += 2;
      if (r.n !== n) begin n_err++; $display("FAIL b2b_nonce%0d got %h req %h", i, r.n, n); end
      if (r.h !== ref_hash(n)) begin n_err++; $display("FAIL b2b_hash%0d got %h req %h", i, r.h, ref_hash(n)); end
    end
  endtask

  task automatic test_random_runs(input logic [31:0] st0, input int cnt, input string tag);
    res_t r;
    logic [31:0] n;
    for (int i = 0; i < 19; i++) ref_hdr[i] = $urandom;
    write_hdr();
    run(st0, 32'(cnt), 1'b0, tag);
    n_cmp++;
    if (resq.size() !== cnt) begin n_err++; $display("FAIL %s_count got %0d req %0d", tag, resq.size(), cnt); end
    for (int i = 0; i < cnt; i++) begin
      n = st0 + 32'(i);
      r = (resq.size() > i) ? resq[i] : '0;
      n_cmp += 2;
      if (r.n !== n) begin n_err++; $display("FAIL %s_nonce%0d got %h req %h", tag, i, r.n, n); end
      if (r.h !== ref_hash(n)) begin n_err++; $display("FAIL %s_hash%0d got %h req %h", tag, i, r.h, ref_hash(n)); end
    end
  endtask

  task automatic test_stop();
    bit seen;
    set_genesis();
    clear_log();
    @(negedge clk);
    go = 1'b1;
    nonce_start = $urandom;
    nonce_count = 32'd10;
    @(negedge clk);
    go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (starts == 2 && hm_busy && !hs_rq) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL stop_reach got 0 req 1"); end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("stop");
    repeat (4) @(negedge clk);
    n_cmp += 3;
    if (resq.size() !== 0) begin n_err++; $display("FAIL stop_results got %0d req 0", resq.size()); end
    if (starts !== 2) begin n_err++; $display("FAIL stop_starts got %0d req 2", starts); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %0b req 0", busy); end
  endtask

  task automatic test_busy_ignore();
    res_t r;
    int s0;
    clear_log();
    @(negedge clk);
    go = 1'b1;
    nonce_start = 32'h1DAC2B7B;
    nonce_count = 32'd2;
    @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    ld_we = 1'b1;
    ld_addr = 5'd0;
    ld_data = $urandom;
    go = 1'b1;
    nonce_start = 32'h0;
    nonce_count = 32'd5;
    @(negedge clk);
    ld_we = 1'b0;
    go = 1'b0;
    wait_idle("busyign");
    n_cmp++;
    if (resq.size() !== 2) begin n_err++; $display("FAIL busy_count got %0d req 2", resq.size()); end
    for (int i = 0; i < 2; i++) begin
      r = (resq.size() > i) ? resq[i] : '0;
      n_cmp += 2;
      if (r.n !== 32'h1DAC2B7B + 32'(i)) begin n_err++; $display("FAIL busy_nonce%0d got %h", i, r.n); end
      if (r.h !== ref_hash(32'h1DAC2B7B + 32'(i))) begin n_err++; $display("FAIL busy_hash%0d got %h", i, r.h); end
    end
    r = (resq.size() > 1) ? resq[1] : '0;
    n_cmp++;
    if (r.h !== GEN_HASH) begin n_err++; $display("FAIL busy_hdr got %h req %h", r.h, GEN_HASH); end
    s0 = starts;
    @(negedge clk);
    go = 1'b1;
    nonce_count = 32'd0;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL cnt0_busy got %0b req 0", busy); end
    if (starts !== s0) begin n_err++; $display("FAIL cnt0_start got %0d req %0d", starts, s0); end
  endtask

  task automatic test_go_stop();
    res_t r;
    run(GEN_NONCE, 32'd5, 1'b1, "gostop");
    r = (resq.size() > 0) ? resq[0] : '0;
    n_cmp += 3;
    if (resq.size() !== 1) begin n_err++; $display("FAIL gostop_count got %0d req 1", resq.size()); end
    if (r.n !== GEN_NONCE) begin n_err++; $display("FAIL gostop_nonce got %h req %h", r.n, GEN_NONCE); end
    if (r.h !== GEN_HASH) begin n_err++; $display("FAIL gostop_hash got %h req %h", r.h, GEN_HASH); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    res_t r;
    logic [31:0] n;
    clear_log();
    @(negedge clk);
    go = 1'b1;
    nonce_start = GEN_NONCE;
    nonce_count = 32'd3;
    @(negedge clk);
    go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (hm_busy && hs_rq && hm_i > 3) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp += 8;
    if (!seen) begin n_err++; $display("FAIL rmid_feed got 0 req 1"); end
    if (hs_start !== 1'b0 || hs_rdy !== 1'b0) begin
      n_err++; $display("FAIL rmid_hs got %0b%0b req 00", hs_start, hs_rdy);
    end
    if (hs_data !== '0) begin n_err++; $display("FAIL rmid_data got %h req 0", hs_data); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %0b req 0", busy); end
    if (hash_valid !== 1'b0) begin n_err++; $display("FAIL rmid_hv got %0b req 0", hash_valid); end
    if (hash_out !== '0) begin n_err++; $display("FAIL rmid_hash got %h req 0", hash_out); end
    if (nonce_out !== '0) begin n_err++; $display("FAIL rmid_nonce got %h req 0", nonce_out); end
    if (hs_state_in !== IV) begin n_err++; $display("FAIL rmid_sin got %h req %h", hs_state_in, IV); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) ref_hdr[i] = '0;
    n = $urandom;
    run(n, 32'd1, 1'b0, "zerohdr");
    r = (resq.size() > 0) ? resq[0] : '0;
    n_cmp++;
    if (r.h !== ref_hash(n)) begin n_err++; $display("FAIL zerohdr_hash got %h req %h", r.h, ref_hash(n)); end
    set_genesis();
    run(GEN_NONCE, 32'd1, 1'b0, "rmid_gen");
    r = (resq.size() > 0) ? resq[0] : '0;
    n_cmp += 2;
    if (r.h !== GEN_HASH) begin n_err++; $display("FAIL rmid_gen got %h req %h", r.h, GEN_HASH); end
    if (r.n !== GEN_NONCE) begin n_err++; $display("FAIL rmid_gnonce got %h req %h", r.n, GEN_NONCE); end
  endtask

  initial begin
    test_reset();
    test_genesis();
    test_back_to_back();
    test_random_runs(32'hFFFF_FFFF, 2, "wrap");
    for (int k = 0; k < 3; k++)
      test_random_runs($urandom, $urandom_range(1, 3), "rand");
    test_stop();
    set_genesis();
    test_busy_ignore();
    test_go_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
